// File: rtl/spi_slave_rx_pkg.sv
// Shared constants and types for the OLED-link SPI receiver:
// byte geometry, STATUS register layout, register map and receiver states.
package spi_pkg;

  localparam int BYTE_W = 8;
  localparam int FIFO_W = BYTE_W + 1;

  localparam int STAT_VALID     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVF       = 2;
  localparam int STAT_FRAG      = 3;
  localparam int STAT_COUNT_LSB = 4;
  localparam int STAT_COUNT_MSB = 7;
  localparam int STAT_COUNT_W   = STAT_COUNT_MSB - STAT_COUNT_LSB + 1;

  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  typedef enum logic {
    IDLE,
    SHIFT
  } rx_state_e;

endpackage

// File: rtl/spi_slave_rx_if.sv
// Bundles the SPI pins and the Avalon-MM slave port of the receiver.
// The slave modport is the receiver's view; master is the driving side.
interface spi_slave_rx_if;

  logic        sclk;
  logic        mosi;
  logic        csn;
  logic        dcn;
  logic        address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport slave (
    input  sclk, mosi, csn, dcn, address, read, write, writedata,
    output readdata, irq
  );

  modport master (
    output sclk, mosi, csn, dcn, address, read, write, writedata,
    input  readdata, irq
  );

endinterface

// File: rtl/spi_slave_rx_fifo.sv
// Small synchronous FIFO for received bytes. A pop frees the head slot
// before a push is considered, so a full FIFO can accept a byte while being read.
module spi_rx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_pop;
  logic             do_push;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 receiver with a byte FIFO read by a Nios host over Avalon-MM.
// Inputs are synchronized into clk; bytes are tagged with the data/command flag.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SYNC  = 2
) (
  input logic           clk,
  input logic           reset,
  spi_slave_rx_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(BYTE_W);

  logic [SYNC-1:0]   sclk_sync_q, mosi_sync_q, csn_sync_q, dcn_sync_q;
  logic [SYNC-1:0]   sync_ok_q;
  logic              sclk_d_q;
  logic              csn_prev_q;
  logic              sclk_s, mosi_s, csn_s, dcn_s;
  logic              sclk_rise, csn_fall;
  rx_state_e         state_q, state_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bitcnt_q, bitcnt_d;
  logic              ovf_q, ovf_d;
  logic              frag_q, frag_d;
  logic              byte_done, frag_set, ovf_set;
  logic              pop, flush, clr_ovf, clr_frag;
  logic [FIFO_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [31:0]       status;
  logic              unused_wdata;

  assign sclk_s    = sclk_sync_q[SYNC-1];
  assign mosi_s    = mosi_sync_q[SYNC-1];
  assign csn_s     = csn_sync_q[SYNC-1];
  assign dcn_s     = dcn_sync_q[SYNC-1];
  assign sclk_rise = sclk_s & ~sclk_d_q;
  // csn_prev_q only tracks csn once the chain holds real pin samples, so the
  // chain's reset value never looks like a falling edge after reset.
  assign csn_fall  = csn_prev_q & ~csn_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      csn_sync_q  <= '1;
      dcn_sync_q  <= '0;
      sync_ok_q   <= '0;
      sclk_d_q    <= 1'b0;
      csn_prev_q  <= 1'b0;
      state_q     <= IDLE;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      ovf_q       <= 1'b0;
      frag_q      <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC-2:0], bus.sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC-2:0], bus.mosi};
      csn_sync_q  <= {csn_sync_q[SYNC-2:0], bus.csn};
      dcn_sync_q  <= {dcn_sync_q[SYNC-2:0], bus.dcn};
      sync_ok_q   <= {sync_ok_q[SYNC-2:0], 1'b1};
      sclk_d_q    <= sclk_s;
      csn_prev_q  <= sync_ok_q[SYNC-1] & csn_s;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      ovf_q       <= ovf_d;
      frag_q      <= frag_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    byte_done = 1'b0;
    frag_set  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (csn_fall) begin
          state_d  = SHIFT;
          shift_d  = '0;
          bitcnt_d = '0;
        end
      end
      SHIFT: begin
        if (csn_s) begin
          state_d  = IDLE;
          frag_set = (bitcnt_q != '0);
        end else if (sclk_rise) begin
          shift_d   = {shift_q[BYTE_W-2:0], mosi_s};
          bitcnt_d  = bitcnt_q + BW'(1);
          byte_done = (bitcnt_q == BW'(BYTE_W - 1));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop      = bus.read & (bus.address == ADDR_DATA);
  assign flush    = bus.write & (bus.address == ADDR_STATUS) & bus.writedata[4];
  assign clr_ovf  = bus.write & (bus.address == ADDR_STATUS) & bus.writedata[2];
  assign clr_frag = bus.write & (bus.address == ADDR_STATUS) & bus.writedata[3];
  assign unused_wdata = ^{bus.writedata[31:5], bus.writedata[1:0]};

  // A flush swallows a simultaneous byte silently, so it never counts as overflow.
  assign ovf_set = byte_done & fifo_full & ~pop & ~flush;
  assign ovf_d   = ovf_set | (ovf_q & ~clr_ovf);
  assign frag_d  = frag_set | (frag_q & ~clr_frag);

  spi_rx_fifo #(
    .WIDTH(FIFO_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (byte_done),
    .data_i ({dcn_s, shift_q[BYTE_W-2:0], mosi_s}),
    .pop_i  (pop),
    .flush_i(flush),
    .data_o (fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  always_comb begin
    status = '0;
    status[STAT_VALID] = ~fifo_empty;
    status[STAT_FULL]  = fifo_full;
    status[STAT_OVF]   = ovf_q;
    status[STAT_FRAG]  = frag_q;
    status[STAT_COUNT_MSB:STAT_COUNT_LSB] = STAT_COUNT_W'(fifo_count);
  end

  assign bus.irq      = ~fifo_empty;
  assign bus.readdata = (bus.address == ADDR_STATUS) ? status :
                        fifo_empty ? 32'h0 : {1'b1, 22'b0, fifo_head};

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: drives SPI mode-0 frames and Avalon accesses,
// comparing readdata/irq against hand-computed values.
module tb_spi_slave_rx;

  logic clk;
  logic reset;
  int   testCount;
  int   failCount;
  logic [31:0] rv;

  spi_slave_rx_if bus ();

  spi_slave_rx #(
    .DEPTH(4),
    .SYNC (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic waitClocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic csnAssert();
    @(negedge clk);
    bus.csn = 1'b0;
    waitClocks(5);
  endtask

  task automatic csnRelease();
    waitClocks(5);
    bus.csn = 1'b1;
    waitClocks(5);
  endtask

  // Sends the top nbits of value MSB-first; data changes while sclk is low.
  task automatic applyStimulus(input logic [7:0] value, input int nbits, input logic dc);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      bus.mosi = value[7-i];
      bus.dcn  = dc;
      waitClocks(5);
      bus.sclk = 1'b1;
      waitClocks(5);
      bus.sclk = 1'b0;
    end
  endtask

  // Same as a full byte, but a DATA read is held during the cycle the byte is pushed.
  task automatic applyStimulusWithPop(input logic [7:0] value, input logic dc,
                                      output logic [31:0] readValue);
    readValue = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.mosi = value[7-i];
      bus.dcn  = dc;
      waitClocks(5);
      bus.sclk = 1'b1;
      if (i == 7) begin
        waitClocks(2);
        bus.address = 1'b0;
        bus.read    = 1'b1;
        #1 readValue = bus.readdata;
        waitClocks(1);
        bus.read = 1'b0;
        waitClocks(2);
      end else begin
        waitClocks(5);
      end
      bus.sclk = 1'b0;
    end
  endtask

  task automatic busRead(input logic addr, output logic [31:0] data);
    @(negedge clk);
    bus.address = addr;
    bus.read    = 1'b1;
    #1 data = bus.readdata;
    @(negedge clk);
    bus.read = 1'b0;
  endtask

  task automatic busPeek(input logic addr, output logic [31:0] data);
    @(negedge clk);
    bus.address = addr;
    #1 data = bus.readdata;
  endtask

  task automatic busWrite(input logic addr, input logic [31:0] wd);
    @(negedge clk);
    bus.address   = addr;
    bus.writedata = wd;
    bus.write     = 1'b1;
    @(negedge clk);
    bus.write     = 1'b0;
    bus.writedata = '0;
  endtask

  initial begin
    testCount    = 0;
    failCount    = 0;
    reset        = 1'b1;
    bus.sclk     = 1'b0;
    bus.mosi     = 1'b0;
    bus.csn      = 1'b1;
    bus.dcn      = 1'b0;
    bus.address  = 1'b0;
    bus.read     = 1'b0;
    bus.write    = 1'b0;
    bus.writedata = '0;

    waitClocks(3);
    busPeek(1'b0, rv);  checkOutput("reset_data", rv, 32'h0);
    busPeek(1'b1, rv);  checkOutput("reset_status", rv, 32'h0);
    checkOutput("reset_irq", {31'b0, bus.irq}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    waitClocks(5);

    // single data byte
    csnAssert();
    applyStimulus(8'hA5, 8, 1'b1);
    csnRelease();
    checkOutput("single_irq_high", {31'b0, bus.irq}, 32'h1);
    busRead(1'b0, rv);  checkOutput("single_data", rv, 32'h8000_01A5);
    checkOutput("single_irq_low", {31'b0, bus.irq}, 32'h0);
    busRead(1'b0, rv);  checkOutput("single_empty_read", rv, 32'h0);

    // command burst in one frame
    csnAssert();
    applyStimulus(8'h15, 8, 1'b0);
    applyStimulus(8'h00, 8, 1'b0);
    applyStimulus(8'h5F, 8, 1'b0);
    csnRelease();
    busPeek(1'b1, rv);  checkOutput("burst_status", rv, 32'h0000_0031);
    busRead(1'b0, rv);  checkOutput("burst_0", rv, 32'h8000_0015);
    busRead(1'b0, rv);  checkOutput("burst_1", rv, 32'h8000_0000);
    busRead(1'b0, rv);  checkOutput("burst_2", rv, 32'h8000_005F);
    busPeek(1'b1, rv);  checkOutput("burst_status_after", rv, 32'h0);

    // overflow: DEPTH+1 bytes without reads
    csnAssert();
    for (int b = 1; b <= 5; b++) applyStimulus(8'(b), 8, 1'b0);
    csnRelease();
    busPeek(1'b1, rv);  checkOutput("ovf_status", rv, 32'h0000_0047);
    checkOutput("ovf_irq", {31'b0, bus.irq}, 32'h1);
    busWrite(1'b1, 32'h4);
    busPeek(1'b1, rv);  checkOutput("ovf_cleared", rv, 32'h0000_0043);
    for (int b = 1; b <= 4; b++) begin
      busRead(1'b0, rv);
      checkOutput($sformatf("ovf_read_%0d", b), rv, 32'h8000_0000 | 32'(b));
    end
    busPeek(1'b1, rv);  checkOutput("ovf_drained", rv, 32'h0);

    // fragment then a clean byte
    csnAssert();
    applyStimulus(8'hF8, 5, 1'b0);
    csnRelease();
    busPeek(1'b1, rv);  checkOutput("frag_status", rv, 32'h0000_0008);
    busPeek(1'b0, rv);  checkOutput("frag_data_empty", rv, 32'h0);
    csnAssert();
    applyStimulus(8'h3C, 8, 1'b0);
    csnRelease();
    busRead(1'b0, rv);  checkOutput("frag_next_byte", rv, 32'h8000_003C);
    busWrite(1'b1, 32'h8);
    busPeek(1'b1, rv);  checkOutput("frag_cleared", rv, 32'h0);

    // flush discards queued bytes
    csnAssert();
    applyStimulus(8'h66, 8, 1'b1);
    applyStimulus(8'h77, 8, 1'b1);
    csnRelease();
    busPeek(1'b1, rv);  checkOutput("flush_before", rv, 32'h0000_0021);
    busWrite(1'b1, 32'h10);
    busPeek(1'b1, rv);  checkOutput("flush_after", rv, 32'h0);

    // full FIFO with a pop on the push cycle
    csnAssert();
    for (int b = 0; b < 4; b++) applyStimulus(8'h10 + 8'(b), 8, 1'b0);
    applyStimulusWithPop(8'h14, 1'b0, rv);
    checkOutput("fullpop_read", rv, 32'h8000_0010);
    csnRelease();
    busPeek(1'b1, rv);  checkOutput("fullpop_status", rv, 32'h0000_0043);
    for (int b = 1; b <= 4; b++) begin
      busRead(1'b0, rv);
      checkOutput($sformatf("fullpop_drain_%0d", b), rv, 32'h8000_0010 | 32'(b));
    end

    // async reset mid-byte; csn stays low, so no byte until a fresh falling edge
    csnAssert();
    applyStimulus(8'h81, 3, 1'b1);
    #3 reset = 1'b1;
    waitClocks(2);
    reset = 1'b0;
    waitClocks(5);
    busPeek(1'b1, rv);  checkOutput("rst_status_clean", rv, 32'h0);
    applyStimulus(8'h81, 8, 1'b1);
    waitClocks(5);
    busPeek(1'b1, rv);  checkOutput("rst_no_stale_frame", rv, 32'h0);
    csnRelease();
    busPeek(1'b1, rv);  checkOutput("rst_no_frag", rv, 32'h0);
    csnAssert();
    applyStimulus(8'h81, 8, 1'b1);
    csnRelease();
    busRead(1'b0, rv);  checkOutput("rst_fresh_byte", rv, 32'h8000_0181);
    busPeek(1'b1, rv);  checkOutput("rst_final_status", rv, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

SPI receiver for the OLED display link: the far end of the SPI master. It samples the sclk/mosi/csn/dcn lines in the system clock domain, assembles MSB-first bytes, tags each byte with its data/command flag, and buffers them in a small FIFO. A Nios/Avalon-MM host reads the FIFO through a zero-wait-state slave port. Uses: bench model of the SSD1331 and loop-back self-test of the display path.

## Interface

**Parameters**
- DEPTH, 4: FIFO entries; power of two, ≥2.
- SYNC, 2: synchronizer flops per SPI input; ≥2.

**Ports**
- clk  in  1  system clock. One clock; all state in this domain.
- reset  in  1  asynchronous, active-high reset.
- sclk  in  1  SPI clock from the master; asynchronous to clk.
- mosi  in  1  serial data; MSB first.
- csn  in  1  chip select, active low.
- dcn  in  1  0 = command byte, 1 = data byte; sampled with bit 0.
- address  in  1  0 = DATA register, 1 = STATUS register.
- read  in  1  Avalon read strobe, one cycle.
- write  in  1  Avalon write strobe, one cycle.
- writedata  in  32  control word; only the STATUS write is defined.
- readdata  out  32  combinational read data.
- irq  out  1  high while the FIFO is non-empty.

## Operation

- Input conditioning:
  - sclk, mosi, csn and dcn each pass through SYNC flops.
  - One more flop on sclk gives the edge detector: rise = sclk_s & ~sclk_d.
  - This is SPI mode 0: bits are sampled only on a rising edge of sclk.
- Receiver states:
  - IDLE: csn_s = 1.
  - SHIFT: csn_s = 0.
  - IDLE → SHIFT when csn_s falls. On entry, bit count = 0 and the shift register is cleared.
  - SHIFT → IDLE when csn_s rises.
- In SHIFT, each rise does shift = {shift[6:0], mosi_s} and increments the bit count.
- On the 8th rise:
  - Push {dcn_s, shift[6:0], mosi_s} (9 bits) into the FIFO.
  - Bit count returns to 0, so consecutive bytes within one csn frame are supported.
- Partial byte: if csn_s rises with bit count ≠ 0, the partial bits are discarded and sticky FRAG is set.
- Rises while csn_s = 1 are ignored.
- FIFO full and a new byte completes: the byte is dropped, the FIFO is unchanged, and sticky OVF is set.
- Push and pop in the same cycle:
  - When full, the pop happens first and the push succeeds; no OVF.
  - When empty, only the push takes effect. A pop of an empty FIFO does nothing.
- DATA read (address 0):
  - readdata = {VALID, 22'b0, dc, byte[7:0]}, where VALID = non-empty.
  - When VALID = 1, the read pops the head. When empty, readdata = 0 and nothing changes.
- STATUS read (address 1):
  - readdata bit 0 = VALID, bit 1 = FULL, bit 2 = OVF, bit 3 = FRAG.
  - Bits [7:4] = occupancy count, zero-extended. All other bits 0.
  - No side effects.
- STATUS write (address 1):
  - writedata[2] = 1 clears OVF.
  - writedata[3] = 1 clears FRAG.
  - writedata[4] = 1 flushes the FIFO.
  - If a push occurs in the same cycle as a flush, the flush wins and the byte is lost.
  - If a sticky bit is set and cleared in the same cycle, the set wins.
- DATA write (address 0): ignored.
- Read and write asserted together: both take effect independently.
- Arithmetic:
  - FIFO pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - The count is $clog2(DEPTH)+1 bits.

## Timing

- Reset values:
  - readdata reflects the empty FIFO: DATA = 0, STATUS = 0.
  - irq = 0.
  - FIFO, OVF and FRAG are cleared.
  - Receiver is in IDLE; synchronizer flops are 1 for csn and 0 for the other inputs.
- Reset mid-byte: partial data is lost and FRAG is not set. After release, the first byte is accepted only after a fresh csn falling edge.
- Latency from the 8th sclk rising edge at the pin:
  - SYNC+1 clk cycles until the rise is detected.
  - The byte appears in the FIFO on the clk edge after detection.
  - irq and VALID rise on that same edge.
- readdata is combinational from address and FIFO/status state; zero wait states. The pop occurs on the clk edge that ends the read cycle.
- Input constraints:
  - sclk high time and low time are each ≥ SYNC+1 clk periods.
  - mosi and dcn are stable from before the rising edge until SYNC+1 cycles after it, which the master's half-period hold guarantees.
  - csn setup before the first sclk edge is ≥ SYNC+1 cycles.

## Structure

- Package spi_pkg holds:
  - the SPI byte width constant (8);
  - STATUS bit positions (VALID 0, FULL 1, OVF 2, FRAG 3, COUNT 7:4);
  - register address constants;
  - the receiver state enum (IDLE, SHIFT).
- One sub-module, spi_rx_fifo: synchronous FIFO parameterized by width (9) and DEPTH, with push, pop, flush, full, empty and count. It implements the pop-before-push rule.
- The top level contains the synchronizers, edge detector, shift FSM, sticky flags and Avalon decode.

## Test plan

- Single byte: csn low, send 0xA5 with dcn = 1, csn high. Expect irq high. DATA read = 0x800001A5, then irq low. A second DATA read = 0x00000000.
- Command burst: send 0x15, 0x00, 0x5F in one frame with dcn = 0. Expect three DATA reads of 0x80000015, 0x80000000, 0x8000005F. Expect FRAG = 0.
- Overflow: send DEPTH+1 bytes 0x01..0x05 with DEPTH = 4 and no reads. Expect STATUS = 0x47 (count 4, OVF, FULL, VALID), reads 0x01..0x04, and 0x05 lost. Write 0x4 to STATUS clears OVF.
- Fragment: send 5 bits then raise csn. Expect STATUS = 0x08 and an empty FIFO. Then send 0x3C in a new frame: it is received correctly.
- Full with simultaneous pop: with the FIFO full, time a DATA read onto the push cycle of a new byte. Expect no OVF and occupancy to stay at 4.
- Async reset: assert reset between bits 3 and 4, release, send 0x81. Expect 0x81 received only after a new csn falling edge, with STATUS clean before that.
